// File: rtl/datapath_core.sv
// Single-bus 32-bit CPU datapath: register file, special registers, bus encoder and ALU.
// The register contents and the bus are brought out as observation ports.
module datapath_core (
    input  logic              Clock,
    input  logic              clear,
    input  logic [31:0]       Mdatain,
    input  logic              Read,
    input  logic              IncPC,
    input  logic [15:0]       Rin,
    input  logic [15:0]       Rout,
    input  logic              PCin,
    input  logic              Zin,
    input  logic              MDRin,
    input  logic              MARin,
    input  logic              Yin,
    input  logic              HIin,
    input  logic              LOin,
    input  logic              PCout,
    input  logic              Zhighout,
    input  logic              Zlowout,
    input  logic              HIout,
    input  logic              LOout,
    input  logic              MDRout,
    input  logic              Cout,
    input  logic [4:0]        opcode,
    output logic [31:0]       bus_o,
    output logic [15:0][31:0] r_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       ir_o,
    output logic [31:0]       y_o,
    output logic [31:0]       mar_o,
    output logic [31:0]       mdr_o,
    output logic [31:0]       hi_o,
    output logic [31:0]       lo_o,
    output logic [63:0]       z_o
);

    logic [15:0][31:0] r_q;
    logic [31:0]       pc_q, ir_q, y_q, mar_q, mdr_q, hi_q, lo_q;
    logic [63:0]       z_q;

    logic [31:0]       busValue;
    logic [31:0]       cSext;
    logic [31:0]       mdr_d;
    logic [63:0]       z_d;
    logic              irLoad;

    logic [4:0]        shAmt;
    logic [31:0]       rorValue, rolValue;
    logic signed [63:0] product;
    logic signed [31:0] quotient, remainder;

    assign cSext = {{13{ir_q[18]}}, ir_q[18:0]};

    // Later assignments win, so sources are listed from lowest to highest priority.
    always_comb begin
        busValue = '0;
        if (Cout)     busValue = cSext;
        if (MDRout)   busValue = mdr_q;
        if (PCout)    busValue = pc_q;
        if (Zlowout)  busValue = z_q[31:0];
        if (Zhighout) busValue = z_q[63:32];
        if (LOout)    busValue = lo_q;
        if (HIout)    busValue = hi_q;
        for (int i = 15; i >= 0; i--) begin
            if (Rout[i]) busValue = r_q[i];
        end
    end

    // IR has no enable of its own; it loads on a bare MDR transfer that targets no GPR or Z.
    assign irLoad = (Rin == 16'h0000) && MDRout && !Zin;

    assign mdr_d = Read ? Mdatain : busValue;

    assign shAmt    = busValue[4:0];
    assign rorValue = (y_q >> shAmt) | (y_q << (6'd32 - 6'(shAmt)));
    assign rolValue = (y_q << shAmt) | (y_q >> (6'd32 - 6'(shAmt)));
    assign product  = 64'($signed(y_q)) * 64'($signed(busValue));

    always_comb begin
        quotient  = 32'hFFFF_FFFF;
        remainder = $signed(y_q);
        if (busValue != 32'h0000_0000) begin
            quotient  = $signed(y_q) / $signed(busValue);
            remainder = $signed(y_q) % $signed(busValue);
        end
    end

    always_comb begin
        z_d = {32'h0000_0000, y_q + busValue};
        if (IncPC) begin
            z_d = {32'h0000_0000, busValue + 32'd1};
        end else begin
            case (opcode)
                5'b00100: z_d = {32'h0000_0000, y_q - busValue};
                5'b00101: z_d = {32'h0000_0000, y_q & busValue};
                5'b00110: z_d = {32'h0000_0000, y_q | busValue};
                5'b00111: z_d = {32'h0000_0000, y_q >> shAmt};
                5'b01000: z_d = {32'h0000_0000, 32'($signed(y_q) >>> shAmt)};
                5'b01001: z_d = {32'h0000_0000, y_q << shAmt};
                5'b01010: z_d = {32'h0000_0000, rorValue};
                5'b01011: z_d = {32'h0000_0000, rolValue};
                5'b01100: z_d = {32'h0000_0000, y_q + busValue};
                5'b01101: z_d = {32'h0000_0000, y_q & busValue};
                5'b01110: z_d = {32'h0000_0000, y_q | busValue};
                5'b01111: z_d = product;
                5'b10000: z_d = {remainder, quotient};
                5'b10001: z_d = {32'h0000_0000, 32'd0 - busValue};
                5'b10010: z_d = {32'h0000_0000, ~busValue};
                default:  z_d = {32'h0000_0000, y_q + busValue};
            endcase
        end
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            r_q   <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            y_q   <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            z_q   <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (Rin[i]) r_q[i] <= busValue;
            end
            if (PCin)   pc_q  <= busValue;
            if (irLoad) ir_q  <= busValue;
            if (Yin)    y_q   <= busValue;
            if (MARin)  mar_q <= busValue;
            if (MDRin)  mdr_q <= mdr_d;
            if (HIin)   hi_q  <= busValue;
            if (LOin)   lo_q  <= busValue;
            if (Zin)    z_q   <= z_d;
        end
    end

    assign bus_o = busValue;
    assign r_o   = r_q;
    assign pc_o  = pc_q;
    assign ir_o  = ir_q;
    assign y_o   = y_q;
    assign mar_o = mar_q;
    assign mdr_o = mdr_q;
    assign hi_o  = hi_q;
    assign lo_o  = lo_q;
    assign z_o   = z_q;

endmodule

// File: tb/tb_datapath_core.sv
// Directed testbench for datapath_core: hand-computed register-transfer sequences
// checked with immediate assertions after each clock edge.
module tb_datapath_core;

    logic              Clock = 1'b0;
    logic              clear;
    logic [31:0]       Mdatain;
    logic              Read, IncPC;
    logic [15:0]       Rin, Rout;
    logic              PCin, Zin, MDRin, MARin, Yin, HIin, LOin;
    logic              PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout;
    logic [4:0]        opcode;
    logic [31:0]       bus_o;
    logic [15:0][31:0] r_o;
    logic [31:0]       pc_o, ir_o, y_o, mar_o, mdr_o, hi_o, lo_o;
    logic [63:0]       z_o;

    int checkCount = 0;
    int errCount   = 0;

    datapath_core dut (
        .Clock(Clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .IncPC(IncPC),
        .Rin(Rin), .Rout(Rout), .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .PCout(PCout), .Zhighout(Zhighout),
        .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout), .MDRout(MDRout), .Cout(Cout),
        .opcode(opcode), .bus_o(bus_o), .r_o(r_o), .pc_o(pc_o), .ir_o(ir_o), .y_o(y_o),
        .mar_o(mar_o), .mdr_o(mdr_o), .hi_o(hi_o), .lo_o(lo_o), .z_o(z_o)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic idleControls();
        Mdatain = '0; Read = 0; IncPC = 0; Rin = '0; Rout = '0;
        PCin = 0; Zin = 0; MDRin = 0; MARin = 0; Yin = 0; HIin = 0; LOin = 0;
        PCout = 0; Zhighout = 0; Zlowout = 0; HIout = 0; LOout = 0; MDRout = 0; Cout = 0;
        opcode = 5'b00011;
    endtask

    // One clock edge with the current controls, then drop every control back to idle.
    task automatic applyStimulus();
        @(posedge Clock);
        #1;
        idleControls();
    endtask

    task automatic loadViaMdr(input logic [31:0] value);
        Mdatain = value; Read = 1; MDRin = 1;
        applyStimulus();
    endtask

    initial begin
        idleControls();
        clear = 1'b0;
        #12;
        checkOutput("reset_r0",  64'(r_o[0]), 64'h0);
        checkOutput("reset_pc",  64'(pc_o),   64'h0);
        checkOutput("reset_z",   z_o,         64'h0);
        checkOutput("idle_bus",  64'(bus_o),  64'h0);
        clear = 1'b1;
        applyStimulus();

        loadViaMdr(32'h12);
        checkOutput("mdr_read", 64'(mdr_o), 64'h12);
        MDRout = 1; Rin[0] = 1;
        applyStimulus();
        checkOutput("r0_load", 64'(r_o[0]), 64'h12);
        checkOutput("ir_hold", 64'(ir_o),   64'h0);
        loadViaMdr(32'h14);
        MDRout = 1; Rin[1] = 1;
        applyStimulus();
        checkOutput("r1_load", 64'(r_o[1]), 64'h14);

        Rout[1] = 1; opcode = 5'b10001; Zin = 1;
        applyStimulus();
        Zlowout = 1; Rin[0] = 1;
        applyStimulus();
        checkOutput("neg_r0", 64'(r_o[0]), 64'hFFFF_FFEC);
        checkOutput("neg_r1", 64'(r_o[1]), 64'h14);

        Rout = 16'h0003; HIout = 1; PCout = 1;
        #1;
        checkOutput("bus_priority", 64'(bus_o), 64'hFFFF_FFEC);
        idleControls();

        Rout[0] = 1; Rin = 16'h000C;
        applyStimulus();
        checkOutput("multi_r2", 64'(r_o[2]), 64'hFFFF_FFEC);
        checkOutput("multi_r3", 64'(r_o[3]), 64'hFFFF_FFEC);

        loadViaMdr(32'd7);
        MDRout = 1; Yin = 1;
        applyStimulus();
        checkOutput("y_load",  64'(y_o),  64'd7);
        checkOutput("ir_load", 64'(ir_o), 64'd7);
        loadViaMdr(32'hFFFF_FFFE);
        MDRout = 1; Zin = 1; opcode = 5'b01111;
        applyStimulus();
        checkOutput("mul", z_o, 64'hFFFF_FFFF_FFFF_FFF2);
        checkOutput("ir_no_load_zin", 64'(ir_o), 64'd7);

        loadViaMdr(32'd17);
        MDRout = 1; Yin = 1;
        applyStimulus();
        loadViaMdr(32'd5);
        MDRout = 1; Zin = 1; opcode = 5'b10000;
        applyStimulus();
        checkOutput("div", z_o, {32'd2, 32'd3});
        Zin = 1; opcode = 5'b10000;
        applyStimulus();
        checkOutput("div_zero", z_o, {32'd17, 32'hFFFF_FFFF});

        loadViaMdr(32'h10);
        MDRout = 1; PCin = 1;
        applyStimulus();
        checkOutput("pc_load", 64'(pc_o), 64'h10);
        PCout = 1; IncPC = 1; Zin = 1; MARin = 1; opcode = 5'b00100;
        applyStimulus();
        checkOutput("incpc_mar", 64'(mar_o), 64'h10);
        checkOutput("incpc_z",   z_o,        64'h11);
        Zlowout = 1; PCin = 1;
        applyStimulus();
        checkOutput("pc_inc", 64'(pc_o), 64'h11);

        loadViaMdr(32'h8000_0001);
        MDRout = 1; Yin = 1;
        applyStimulus();
        loadViaMdr(32'd1);
        MDRout = 1; Zin = 1; opcode = 5'b01010;
        applyStimulus();
        checkOutput("ror", z_o, 64'hC000_0000);
        MDRout = 1; Zin = 1; opcode = 5'b01000;
        applyStimulus();
        checkOutput("shra", z_o, 64'hC000_0000);
        MDRout = 1; Zin = 1; opcode = 5'b00111;
        applyStimulus();
        checkOutput("shr", z_o, 64'h4000_0000);
        MDRout = 1; Zin = 1; opcode = 5'b01011;
        applyStimulus();
        checkOutput("rol", z_o, 64'h0000_0003);

        loadViaMdr(32'hFFF4_0000);
        MDRout = 1; Zin = 1; opcode = 5'b00011;
        applyStimulus();
        checkOutput("add_wrap", z_o, 64'h7FF4_0001);
        MDRout = 1; Zin = 1; opcode = 5'b00100;
        applyStimulus();
        checkOutput("sub", z_o, 64'h800C_0001);
        MDRout = 1;
        applyStimulus();
        checkOutput("ir_mdr", 64'(ir_o), 64'hFFF4_0000);
        Cout = 1;
        #1;
        checkOutput("cout_sext", 64'(bus_o), 64'hFFFC_0000);
        idleControls();

        loadViaMdr(32'hDEAD);
        MDRout = 1; Rin[5] = 1;
        applyStimulus();
        checkOutput("r5_load", 64'(r_o[5]), 64'hDEAD);
        #2;
        clear = 1'b0;
        #1;
        checkOutput("async_r5",  64'(r_o[5]), 64'h0);
        checkOutput("async_r0",  64'(r_o[0]), 64'h0);
        checkOutput("async_pc",  64'(pc_o),   64'h0);
        checkOutput("async_y",   64'(y_o),    64'h0);
        checkOutput("async_mdr", 64'(mdr_o),  64'h0);
        checkOutput("async_ir",  64'(ir_o),   64'h0);
        checkOutput("async_z",   z_o,         64'h0);
        Mdatain = 32'h55; Read = 1; MDRin = 1;
        applyStimulus();
        checkOutput("load_blocked", 64'(mdr_o), 64'h0);
        clear = 1'b1;
        loadViaMdr(32'h55);
        checkOutput("resume_mdr", 64'(mdr_o), 64'h55);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
        $finish;
    end

endmodule
